branch_hazard_ctrl: RTL
=======================

Name: branch_hazard_ctrl

Overview:
- Controls the ID-stage branch comparison operand muxes.
- Tracks the destination registers of the three older in-flight instructions (EX, MEM, WB slots) in an internal scoreboard pipeline.
- Produces the 4-bit forward_c select for the branch operand selector (00 rd, 01 alu, 10 exmem_alu, 11 wb_data).
- Stalls ID when a branch source is produced by a load that is still in EX or MEM, and counts those stall cycles for performance monitoring.

Parameters:
- RA_W, 4, register address width (16 architectural registers).
- ZERO_FWD, 0, when 0 register r0 is never forwarded and never stalls; when 1 r0 is treated like any other register.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_is_branch  input  1  ID instruction is a branch (compares rs1/rs2 in ID).
- id_rs1  input  RA_W  branch source 1 address.
- id_rs2  input  RA_W  branch source 2 address.
- id_wr_en  input  1  ID instruction writes a register.
- id_rd  input  RA_W  ID instruction destination.
- id_is_load  input  1  ID instruction is a memory load.
- ext_stall  input  1  global pipeline freeze (memory wait); all slots hold.
- cnt_clr  input  1  synchronous clear of stall_cnt.
- forward_c  output  4  [1:0] rs1 select, [3:2] rs2 select.
- stall_id  output  1  hold PC and IF/ID; bubble into EX.
- stall_cnt  output  CNT_W  saturating count of hazard stall cycles.

Behaviour:
- Scoreboard: three slots EX, MEM, WB, each holding {vld, rd, ld}. All vld=0 on reset; rd and ld also reset to 0.
- Slot advance each rising clk:
  - ext_stall=1: all slots hold.
  - Else if haz=1: EX<=bubble (vld=0), MEM<=EX, WB<=MEM.
  - Else: EX<={id_valid&id_wr_en, id_rd, id_is_load}, MEM<=EX, WB<=MEM.
- Match for source s in slot X: X.vld & (X.rd==s) & (ZERO_FWD | s!=0).
- Per-source select, combinational, priority youngest first:
  - EX match & !ld -> 01.
  - EX match & ld -> 00, and raise hazard.
  - MEM match & !ld -> 10.
  - MEM match & ld -> 00, and raise hazard.
  - WB match -> 11.
  - No match -> 00.
- Qualification: when !(id_valid & id_is_branch), forward_c=0000 and no hazard is raised.
- Both sources are evaluated independently. haz = OR of both sources' hazards.
- stall_id = haz | ext_stall.
- Outputs after reset: forward_c=0000 (all slots invalid), stall_id=ext_stall, stall_cnt=0.
- Load-use latency: a branch behind a load in EX stalls 2 cycles, then gets 11. A branch behind a load in MEM stalls 1 cycle, then gets 11.
- stall_cnt:
  - Increments by 1 on each clk where haz=1 and ext_stall=0.
  - Saturates at all-ones.
  - cnt_clr has priority over increment; the counter reads 0 the next cycle.
  - ext_stall-only cycles are not counted.
- Simultaneous events:
  - ext_stall with haz: slots frozen and no count.
  - Hazard re-evaluates each cycle from the frozen slots.
- Reset mid-operation: rst_n low clears slots and counter immediately (asynchronous). forward_c goes to 0000 in the same delta, independent of clk.
- Same register as both sources: both fields carry the same select.
- Multiple slots matching: the youngest slot wins. Example: EX non-load and WB both write r3 -> 01.

Test Plan:
- Reset, then non-load ADD writing r5 issued, then a branch reading rs1=r5, rs2=r2 the next cycle -> forward_c=0001, stall_id=0.
- LOAD to r4, then a branch with rs2=r4 immediately -> stall_id=1 for 2 cycles, forward_c=0000 during the stall, then 1100 with stall_id=0; stall_cnt=2.
- ADD r7, unrelated instruction, unrelated instruction, branch rs1=r7 -> forward_c=0011 (WB). One further instruction between -> 0000.
- ADD r3 in WB, SUB r3 in MEM, branch rs1=rs2=r3 -> forward_c=1010. Same sequence with ZERO_FWD=0 and r0 in place of r3 -> 0000.
- LOAD r1 in EX with ext_stall=1 for 3 cycles -> slots frozen, stall_id=1, stall_cnt unchanged. After release, 2 hazard cycles follow -> stall_cnt +2.
- Preload stall_cnt to all-ones via repeated hazards, then another hazard -> count stays all-ones. Assert cnt_clr -> 0. rst_n low mid-stall -> stall_id=ext_stall and forward_c=0000 immediately.

Source files
------------

// File: rtl/branch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// branch_hazard_ctrl
//
// Purpose:
//   Drives the ID-stage branch comparator operand muxes.
//   A three-entry scoreboard (EX, MEM, WB) records the destination register
//   of each older in-flight instruction, and whether that instruction is a load.
//   From the scoreboard, the block picks a forwarding source for each branch
//   operand.
//   It stalls ID while a branch operand is still being produced by a load in
//   EX or MEM.
//   It also counts those hazard stall cycles for performance monitoring.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   id_valid      ID stage holds a real instruction
//   id_is_branch  ID instruction is a branch (compares rs1/rs2 in ID)
//   id_rs1/rs2    branch source register addresses
//   id_wr_en      ID instruction writes a register
//   id_rd         ID instruction destination register
//   id_is_load    ID instruction is a memory load
//   ext_stall     global pipeline freeze; all scoreboard slots hold
//   cnt_clr       synchronous clear of stall_cnt
//   forward_c     [1:0] rs1 select, [3:2] rs2 select
//                 (00 rd, 01 alu, 10 exmem_alu, 11 wb_data)
//   stall_id      hold PC and IF/ID, bubble into EX
//   stall_cnt     saturating count of hazard stall cycles
// ---------------------------------------------------------------------------
module branch_hazard_ctrl #(
  parameter int RA_W     = 4,
  parameter bit ZERO_FWD = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_is_branch,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_wr_en,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_is_load,
  input  logic             ext_stall,
  input  logic             cnt_clr,
  output logic [3:0]       forward_c,
  output logic             stall_id,
  output logic [CNT_W-1:0] stall_cnt
);

  // Scoreboard slots.
  // WB data is forwardable whether or not it came from a load,
  // so the WB slot carries no load flag.
  logic            ex_vld, mem_vld, wb_vld;
  logic [RA_W-1:0] ex_rd, mem_rd, wb_rd;
  logic            ex_ld, mem_ld;

  logic            haz;
  logic [2:0]      sel_rs1, sel_rs2;

  // Returns {hazard, select[1:0]} for one source register.
  // The slots are searched from youngest to oldest, so the most recent
  // producer wins.
  // A load still in EX or MEM has no data yet: the select stays 00 and a
  // hazard is raised instead.
  function automatic logic [2:0] pick_src(
    input logic [RA_W-1:0] src,
    input logic            exv,
    input logic [RA_W-1:0] exr,
    input logic            exl,
    input logic            memv,
    input logic [RA_W-1:0] memr,
    input logic            meml,
    input logic            wbv,
    input logic [RA_W-1:0] wbr
  );
    logic ok;
    ok       = ZERO_FWD || (src != '0);
    pick_src = 3'b000;
    if (ok && exv && (exr == src)) begin
      pick_src = exl ? 3'b100 : 3'b001;
    end else if (ok && memv && (memr == src)) begin
      pick_src = meml ? 3'b100 : 3'b010;
    end else if (ok && wbv && (wbr == src)) begin
      pick_src = 3'b011;
    end
  endfunction

  // Operand selection and hazard detection.
  // Both outputs are forced quiet unless ID holds a valid branch.
  always_comb begin
    sel_rs1   = pick_src(id_rs1, ex_vld, ex_rd, ex_ld, mem_vld, mem_rd, mem_ld,
                         wb_vld, wb_rd);
    sel_rs2   = pick_src(id_rs2, ex_vld, ex_rd, ex_ld, mem_vld, mem_rd, mem_ld,
                         wb_vld, wb_rd);
    forward_c = 4'b0000;
    haz       = 1'b0;
    if (id_valid && id_is_branch) begin
      forward_c = {sel_rs2[1:0], sel_rs1[1:0]};
      haz       = sel_rs1[2] | sel_rs2[2];
    end
  end

  assign stall_id = haz | ext_stall;

  // Scoreboard advance.
  // A global freeze holds every slot.
  // A hazard stall injects a bubble into EX while older entries keep draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_vld  <= 1'b0;
      ex_rd   <= '0;
      ex_ld   <= 1'b0;
      mem_vld <= 1'b0;
      mem_rd  <= '0;
      mem_ld  <= 1'b0;
      wb_vld  <= 1'b0;
      wb_rd   <= '0;
    end else if (!ext_stall) begin
      wb_vld  <= mem_vld;
      wb_rd   <= mem_rd;
      mem_vld <= ex_vld;
      mem_rd  <= ex_rd;
      mem_ld  <= ex_ld;
      if (haz) begin
        ex_vld <= 1'b0;
        ex_rd  <= '0;
        ex_ld  <= 1'b0;
      end else begin
        ex_vld <= id_valid & id_wr_en;
        ex_rd  <= id_rd;
        ex_ld  <= id_is_load;
      end
    end
  end

  // Hazard stall counter.
  // Clear wins over increment.
  // Cycles stalled only by the global freeze are not hazard stalls and are
  // not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (haz && !ext_stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
